// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared types and helpers for the RAM-backed streaming FIFO controller.
// Holds the status bundle, depth helpers and the skid queue occupancy width.
package sync_fifo_ctrl_pkg;

    localparam int SKID_OCC_W = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // RAM words plus the two words parked in the output skid queue.
    function automatic int unsigned fifo_capacity(input int unsigned aw);
        return fifo_depth(aw) + 32'd2;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output queue that catches words landing from the RAM read port.
// Entry 0 is always the head; it only changes on a pop or a push into an empty queue.
module fifo_out_skid
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [SKID_OCC_W-1:0] occ,
    output logic [SKID_OCC_W-1:0] occ_nxt
);

    logic [DATA_WIDTH-1:0] e0;
    logic [DATA_WIDTH-1:0] e1;

    always_comb begin
        occ_nxt = occ;
        unique case ({push, pop})
            2'b10:   occ_nxt = occ + SKID_OCC_W'(1);
            2'b01:   occ_nxt = occ - SKID_OCC_W'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0  <= '0;
            e1  <= '0;
            occ <= '0;
        end else begin
            occ <= occ_nxt;
            if (push && pop) begin
                if (occ == SKID_OCC_W'(2)) begin
                    e0 <= e1;
                    e1 <= din;
                end else begin
                    e0 <= din;
                end
            end else if (pop) begin
                e0 <= e1;
            end else if (push) begin
                if (occ == '0) e0 <= din;
                else           e1 <= din;
            end
        end
    end

    assign dout = e0;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Streaming FIFO controller in front of a dual-port RAM with a registered read port.
// Optional high-water mark port pair enabled by defining SYNC_FIFO_CTRL_PEAK_EN.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
`ifdef SYNC_FIFO_CTRL_PEAK_EN
    ,
    input  logic                  peak_clr,
    output logic [ADDR_WIDTH:0]   peak
`endif
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         ram_cnt;
    logic [CW-1:0]         ram_cnt_n;
    logic                  rd_pend;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            inflight;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_n;
    fifo_status_t          status_q;
    fifo_status_t          status_n;

    logic [SKID_OCC_W-1:0] occ;
    logic [SKID_OCC_W-1:0] occ_n;

    assign s_ready = (ram_cnt < DEPTH_C);
    assign push    = s_valid && s_ready;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    // Prefetch only while the skid queue still has room after this cycle.
    assign inflight = 3'(occ) + 3'(rd_pend);
    assign issue    = (ram_cnt != '0) && (inflight <= (3'd1 + 3'(pop)));

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr;
    assign ram_din_a  = push ? s_data : '0;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr;

    always_comb begin
        ram_cnt_n = ram_cnt;
        unique case ({push, issue})
            2'b10:   ram_cnt_n = ram_cnt + CW'(1);
            2'b01:   ram_cnt_n = ram_cnt - CW'(1);
            default: ram_cnt_n = ram_cnt;
        endcase
    end

    always_comb begin
        count_n = ram_cnt_n + CW'(issue) + CW'(occ_n);
        status_n              = '0;
        status_n.full         = (ram_cnt_n == DEPTH_C);
        status_n.empty        = (count_n == '0);
        status_n.almost_full  = (count_n >= AF_C);
        status_n.almost_empty = (count_n <= AE_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_pend  <= 1'b0;
            count_q  <= '0;
            status_q <= '{full: 1'b0, empty: 1'b1,
                          almost_full: 1'b0, almost_empty: 1'b1};
        end else begin
            if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            ram_cnt  <= ram_cnt_n;
            rd_pend  <= issue;
            count_q  <= count_n;
            status_q <= status_n;
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push   (rd_pend),
        .din    (ram_dout_b),
        .pop    (pop),
        .dout   (m_data),
        .occ    (occ),
        .occ_nxt(occ_n)
    );

    assign count        = count_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;

`ifdef SYNC_FIFO_CTRL_PEAK_EN
    logic [CW-1:0] peak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= count_q;
        end else if (count_n > peak_q) begin
            peak_q <= count_n;
        end
    end

    assign peak = peak_q;
`endif

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the team's dual-port RAM and turns it into a streaming FIFO. RAM port A is the write port and port B the read port. The block owns the pointers, occupancy and status flags, and contains a 2-entry output skid queue. The skid queue hides the RAM's 1-cycle registered read latency, so the output is first-word-fall-through at full throughput.

## Interface
- DATA_WIDTH, 8: word width.
- ADDR_WIDTH, 4: RAM address width, ≥2. DEPTH = 2**ADDR_WIDTH RAM words. Total capacity is DEPTH+2.
- AFULL_THRESH, 14: almost_full when count ≥ this.
- AEMPTY_THRESH, 2: almost_empty when count ≤ this.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  FIFO accepts a word.
- s_data  in  DATA_WIDTH  upstream word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  output word, head of FIFO.
- count  out  ADDR_WIDTH+1  total words held.
- full, empty, almost_full, almost_empty  out  1 each  registered status.
- ram_we_a  out  1  RAM port A write enable.
- ram_addr_a  out  ADDR_WIDTH  RAM port A address.
- ram_din_a  out  DATA_WIDTH  RAM port A write data.
- ram_we_b  out  1  tied 0.
- ram_addr_b  out  ADDR_WIDTH  RAM port B read address.
- ram_dout_b  in  DATA_WIDTH  RAM port B registered read data.

## Operation
- **Push:** s_valid && s_ready in a cycle.
  - Drives ram_we_a=1, ram_addr_a=wr_ptr, ram_din_a=s_data combinationally.
  - wr_ptr increments modulo DEPTH.
  - s_ready = (ram_cnt < DEPTH). It does not depend on s_valid or m_ready.
- **Prefetch read:** issued when ram_cnt > 0 and (out_occ + rd_pend − pop) ≤ 1. Here pop = m_valid && m_ready.
  - ram_addr_b = rd_ptr, driven continuously.
  - On issue, rd_ptr increments modulo DEPTH and rd_pend is set for the next cycle.
- **Landing:** when rd_pend=1, ram_dout_b is written into the skid queue at the end of that cycle.
- **Output:** m_valid = (out_occ ≠ 0); m_data = skid queue head.
- **ram_cnt:** updated by +push − issue. A simultaneous push and issue leaves it unchanged.
- **count:** ram_cnt + rd_pend + out_occ, registered from the next-state values.
- **Flags:**
  - full = (ram_cnt == DEPTH), equal to !s_ready.
  - empty = (count == 0).
  - almost_full and almost_empty are compared against next count and registered, so they align with count.
- **Boundaries:**
  - A push while full is ignored; s_ready is already 0.
  - Pops are only possible while m_valid=1.
  - Pointer wrap is silent.
  - A read is never issued to the address being written in the same cycle: an issue requires ram_cnt>0, and a push at ram_cnt==DEPTH is blocked.
  - RAM collision therefore never occurs.
- **Reset (any time, including mid-burst):**
  - Clears pointers, ram_cnt, rd_pend, out_occ and the skid queue.
  - Outputs: m_valid=0, m_data=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, ram_we_a=0, ram_addr_a=0, ram_addr_b=0, ram_din_a=0.
  - s_ready=1 from reset.
  - In-flight data is discarded.

## Timing
- Empty-FIFO latency: push in cycle 0 → read issued in cycle 1 → ram_dout_b valid in cycle 2 → m_valid=1 in cycle 3.
- Steady state with m_ready=1: one push and one pop per cycle, no bubbles.
- m_data is stable while m_valid && !m_ready.
- count and flags update one edge after the causing handshake.

## Configuration
- Macro: SYNC_FIFO_CTRL_PEAK_EN.
- Defined: adds input peak_clr (1) and output peak (ADDR_WIDTH+1).
  - peak is a registered high-water mark of count, reset to 0.
  - peak_clr loads the current count.
- Undefined: neither port nor register exists. All other behaviour is identical.

## Structure
- Package sync_fifo_ctrl_pkg holds:
  - the status struct type (full, empty, almost_full, almost_empty);
  - the DEPTH/capacity helper function;
  - the skid queue occupancy width constant.
- Sub-module fifo_out_skid is the 2-entry output queue with push/pop/occ. It is instantiated once.

## Test plan
- Reset, then push 0xAA at cycle 0, m_ready=1 → m_valid=1 and m_data=0xAA in cycle 3; count returns to 0; empty=1.
- Push 18 words 0x00..0x11 with m_ready=0 → after the 16th push s_ready stays 1 (skid queue absorbs 2 words); full=1, count=18, almost_full=1; a 19th push is not accepted.
- From the full state, drain with m_ready=1 → outputs 0x00..0x11 in order with no gaps, crossing the pointer wrap; empty=1 at the end.
- Continuous push and pop at one word per cycle, 40 words → count holds at 3 after fill, ram_cnt stays ≤1, data in order, no bubbles.
- Toggle m_ready every cycle during a burst → m_data is held while stalled and no word is duplicated or lost.
- Assert rst with 5 words queued and rd_pend=1 → m_valid=0, count=0, empty=1 immediately; the next push 0x5A emerges at cycle 3 as the first word.
